// File: rtl/adc_pulse_emulator.sv
// -----------------------------------------------------------------------------
// adc_pulse_emulator
//
// Synthetic 4-channel ADC source. It replaces the JESD ADC core output so that
// the trigger / time-of-flight logic can be exercised in closed loop. Each clock
// carries two signed samples per channel: sample 0 in [15:0], sample 1 in [31:16].
// Channels A/B/C carry baseline plus an optional pulse (A, then B, then C, each
// after a programmable delay) and optional 4-bit LFSR noise. Channel D carries
// the raw LFSR state as a noise reference.
//
// Ports
//   rxclk, rxrstn            sample clock, asynchronous active-low reset
//   emu_enable               rising edge latches config and starts; low aborts
//   emu_single               1 = one frame then DONE, 0 = free-running frames
//   cfg_baseline             signed baseline for A/B/C
//   cfg_amp_a/b/c            signed pulse amplitude added to the baseline
//   cfg_width                pulse width in samples (0 = no pulses)
//   cfg_delay_a/ab/bc        pulse start offsets in samples (chained)
//   cfg_period               frame length in samples (LSB ignored, min 2)
//   cfg_noise_en             add LFSR noise to A/B/C
//   adc_data_a..d            sample pairs
//   adc_valid_a..d,
//   adc_enable_a..d, busy    high while a run produces data
//   frame_start              strobe with the first word of every frame
//   frame_cnt                completed frames since the last start
// -----------------------------------------------------------------------------
module adc_pulse_emulator #(
    parameter int          ADC_DATA_WIDTH = 16,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                          rxclk,
    input  logic                          rxrstn,
    input  logic                          emu_enable,
    input  logic                          emu_single,
    input  logic [ADC_DATA_WIDTH-1:0]     cfg_baseline,
    input  logic [ADC_DATA_WIDTH-1:0]     cfg_amp_a,
    input  logic [ADC_DATA_WIDTH-1:0]     cfg_amp_b,
    input  logic [ADC_DATA_WIDTH-1:0]     cfg_amp_c,
    input  logic [15:0]                   cfg_width,
    input  logic [31:0]                   cfg_delay_a,
    input  logic [31:0]                   cfg_delay_ab,
    input  logic [31:0]                   cfg_delay_bc,
    input  logic [31:0]                   cfg_period,
    input  logic                          cfg_noise_en,
    output logic [2*ADC_DATA_WIDTH-1:0]   adc_data_a,
    output logic [2*ADC_DATA_WIDTH-1:0]   adc_data_b,
    output logic [2*ADC_DATA_WIDTH-1:0]   adc_data_c,
    output logic [2*ADC_DATA_WIDTH-1:0]   adc_data_d,
    output logic                          adc_valid_a,
    output logic                          adc_valid_b,
    output logic                          adc_valid_c,
    output logic                          adc_valid_d,
    output logic                          adc_enable_a,
    output logic                          adc_enable_b,
    output logic                          adc_enable_c,
    output logic                          adc_enable_d,
    output logic                          frame_start,
    output logic [31:0]                   frame_cnt,
    output logic                          busy
);

    localparam int W = ADC_DATA_WIDTH;
    localparam logic signed [W+1:0] SAT_MAX = $signed({3'b000, {(W-1){1'b1}}});
    localparam logic signed [W+1:0] SAT_MIN = $signed({3'b111, {(W-1){1'b0}}});

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_en_d;
    logic                 r_single, r_noise;
    logic signed [W-1:0]  r_base, r_amp_a, r_amp_b, r_amp_c;
    logic [15:0]          r_width;
    logic [31:0]          r_sa, r_sb, r_sc, r_period, r_t;
    logic [15:0]          r_lfsr;
    logic [2*W-1:0]       r_data_a, r_data_b, r_data_c, r_data_d;
    logic                 r_valid, r_fs;
    logic [31:0]          r_frame_cnt;

    // Clamp to the W-bit signed range. Two guard bits so that
    // baseline + amplitude + noise can never overflow the intermediate.
    function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
        if (v > SAT_MAX)      return {1'b0, {(W-1){1'b1}}};
        else if (v < SAT_MIN) return {1'b1, {(W-1){1'b0}}};
        else                  return v[W-1:0];
    endfunction

    // 33-bit window test so that start + width never wraps.
    function automatic logic in_pulse(input logic [31:0] s, input logic [15:0] wd,
                                      input logic [32:0] ti);
        return ({1'b0, s} <= ti) && (ti < ({1'b0, s} + {17'd0, wd}));
    endfunction

    function automatic logic [W-1:0] chan_sample(input logic signed [W-1:0] base,
                                                 input logic signed [W-1:0] amp,
                                                 input logic hit,
                                                 input logic [3:0] nz,
                                                 input logic nz_en);
        logic signed [W+1:0] acc;
        acc = {{2{base[W-1]}}, base};
        if (hit)   acc = acc + {{2{amp[W-1]}}, amp};
        if (nz_en) acc = acc + {{(W-2){nz[3]}}, nz};
        return sat(acc);
    endfunction

    logic        w_start, w_run_act, w_wrap;
    logic [32:0] w_t0, w_t1;
    logic [31:0] w_p_raw, w_p_eff, w_sb, w_sc;
    logic [15:0] w_lfsr_nxt;
    logic [2*W-1:0] w_a, w_b, w_c, w_d;

    assign w_start   = emu_enable & ~r_en_d;
    assign w_run_act = (r_state == S_RUN) && emu_enable;
    assign w_t0      = {1'b0, r_t};
    assign w_t1      = {1'b0, r_t} + 33'd1;
    // The period is always even so that a frame holds a whole number of words.
    assign w_wrap    = ({1'b0, r_t} + 33'd2) >= {1'b0, r_period};
    assign w_p_raw   = cfg_period & 32'hFFFF_FFFE;
    assign w_p_eff   = (w_p_raw < 32'd2) ? 32'd2 : w_p_raw;
    assign w_sb      = cfg_delay_a + cfg_delay_ab;
    assign w_sc      = w_sb + cfg_delay_bc;
    // x^16 + x^14 + x^13 + x^11, shifting towards the MSB.
    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    assign w_a = {chan_sample(r_base, r_amp_a, in_pulse(r_sa, r_width, w_t1), r_lfsr[7:4], r_noise),
                  chan_sample(r_base, r_amp_a, in_pulse(r_sa, r_width, w_t0), r_lfsr[3:0], r_noise)};
    assign w_b = {chan_sample(r_base, r_amp_b, in_pulse(r_sb, r_width, w_t1), r_lfsr[7:4], r_noise),
                  chan_sample(r_base, r_amp_b, in_pulse(r_sb, r_width, w_t0), r_lfsr[3:0], r_noise)};
    assign w_c = {chan_sample(r_base, r_amp_c, in_pulse(r_sc, r_width, w_t1), r_lfsr[7:4], r_noise),
                  chan_sample(r_base, r_amp_c, in_pulse(r_sc, r_width, w_t0), r_lfsr[3:0], r_noise)};
    // Noise reference: low LFSR byte is sample 0, high byte is sample 1, both sign-extended.
    assign w_d = {{(W-8){r_lfsr[15]}}, r_lfsr[15:8], {(W-8){r_lfsr[7]}}, r_lfsr[7:0]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (!emu_enable)            w_state_nxt = S_IDLE;
                else if (w_wrap && r_single) w_state_nxt = S_DONE;
            end
            S_DONE: if (!emu_enable) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge rxclk or negedge rxrstn) begin
        if (!rxrstn) begin
            r_state     <= S_IDLE;
            r_en_d      <= 1'b0;
            r_single    <= 1'b0;
            r_noise     <= 1'b0;
            r_base      <= '0;
            r_amp_a     <= '0;
            r_amp_b     <= '0;
            r_amp_c     <= '0;
            r_width     <= '0;
            r_sa        <= '0;
            r_sb        <= '0;
            r_sc        <= '0;
            r_period    <= 32'd2;
            r_t         <= '0;
            r_lfsr      <= LFSR_SEED;
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_data_c    <= '0;
            r_data_d    <= '0;
            r_valid     <= 1'b0;
            r_fs        <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_en_d  <= emu_enable;

            if (r_state == S_IDLE && w_start) begin
                r_single    <= emu_single;
                r_noise     <= cfg_noise_en;
                r_base      <= cfg_baseline;
                r_amp_a     <= cfg_amp_a;
                r_amp_b     <= cfg_amp_b;
                r_amp_c     <= cfg_amp_c;
                r_width     <= cfg_width;
                r_sa        <= cfg_delay_a;
                r_sb        <= w_sb;
                r_sc        <= w_sc;
                r_period    <= w_p_eff;
                r_t         <= '0;
                r_lfsr      <= LFSR_SEED;
                r_frame_cnt <= '0;
            end

            if (w_run_act) begin
                r_lfsr <= w_lfsr_nxt;
                if (w_wrap) begin
                    r_t         <= '0;
                    r_frame_cnt <= r_frame_cnt + 32'd1;
                end else begin
                    r_t <= r_t + 32'd2;
                end
            end

            // Output word for (t, t+1) lands one clock after t is presented.
            if (w_run_act) begin
                r_data_a <= w_a;
                r_data_b <= w_b;
                r_data_c <= w_c;
                r_data_d <= w_d;
                r_valid  <= 1'b1;
                r_fs     <= (r_t == 32'd0);
            end else if (r_state == S_DONE) begin
                r_data_a <= {r_base, r_base};
                r_data_b <= {r_base, r_base};
                r_data_c <= {r_base, r_base};
                r_data_d <= {r_base, r_base};
                r_valid  <= 1'b0;
                r_fs     <= 1'b0;
            end else begin
                r_data_a <= '0;
                r_data_b <= '0;
                r_data_c <= '0;
                r_data_d <= '0;
                r_valid  <= 1'b0;
                r_fs     <= 1'b0;
            end
        end
    end

    assign adc_data_a   = r_data_a;
    assign adc_data_b   = r_data_b;
    assign adc_data_c   = r_data_c;
    assign adc_data_d   = r_data_d;
    assign adc_valid_a  = r_valid;
    assign adc_valid_b  = r_valid;
    assign adc_valid_c  = r_valid;
    assign adc_valid_d  = r_valid;
    assign adc_enable_a = r_valid;
    assign adc_enable_b = r_valid;
    assign adc_enable_c = r_valid;
    assign adc_enable_d = r_valid;
    assign busy         = r_valid;
    assign frame_start  = r_fs;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_adc_pulse_emulator.sv
// -----------------------------------------------------------------------------
// Directed testbench for adc_pulse_emulator. Expected values are hand-computed
// from the behavioural description (pulse windows, saturation, LFSR seed words).
// -----------------------------------------------------------------------------
module tb_adc_pulse_emulator;

    logic        rxclk = 1'b0;
    logic        rxrstn;
    logic        emu_enable, emu_single;
    logic [15:0] cfg_baseline, cfg_amp_a, cfg_amp_b, cfg_amp_c, cfg_width;
    logic [31:0] cfg_delay_a, cfg_delay_ab, cfg_delay_bc, cfg_period;
    logic        cfg_noise_en;
    logic [31:0] adc_data_a, adc_data_b, adc_data_c, adc_data_d;
    logic        adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d;
    logic        adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d;
    logic        frame_start, busy;
    logic [31:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ca [0:511];
    logic [31:0] cb [0:511];
    logic [31:0] cc [0:511];
    logic [31:0] cd [0:511];
    logic [31:0] cfc[0:511];
    logic [7:0]  cv [0:511];
    logic        cfs[0:511];
    logic [31:0] saved_d[0:5];

    adc_pulse_emulator dut (
        .rxclk(rxclk), .rxrstn(rxrstn), .emu_enable(emu_enable), .emu_single(emu_single),
        .cfg_baseline(cfg_baseline), .cfg_amp_a(cfg_amp_a), .cfg_amp_b(cfg_amp_b),
        .cfg_amp_c(cfg_amp_c), .cfg_width(cfg_width), .cfg_delay_a(cfg_delay_a),
        .cfg_delay_ab(cfg_delay_ab), .cfg_delay_bc(cfg_delay_bc), .cfg_period(cfg_period),
        .cfg_noise_en(cfg_noise_en),
        .adc_data_a(adc_data_a), .adc_data_b(adc_data_b), .adc_data_c(adc_data_c),
        .adc_data_d(adc_data_d),
        .adc_valid_a(adc_valid_a), .adc_valid_b(adc_valid_b), .adc_valid_c(adc_valid_c),
        .adc_valid_d(adc_valid_d),
        .adc_enable_a(adc_enable_a), .adc_enable_b(adc_enable_b), .adc_enable_c(adc_enable_c),
        .adc_enable_d(adc_enable_d),
        .frame_start(frame_start), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #4 rxclk = ~rxclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge rxclk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] base, input logic [15:0] aa,
                           input logic [15:0] ab, input logic [15:0] ac,
                           input logic [15:0] wd, input logic [31:0] da,
                           input logic [31:0] dab, input logic [31:0] dbc,
                           input logic [31:0] per, input logic single, input logic nz);
        cfg_baseline = base; cfg_amp_a = aa; cfg_amp_b = ab; cfg_amp_c = ac;
        cfg_width = wd; cfg_delay_a = da; cfg_delay_ab = dab; cfg_delay_bc = dbc;
        cfg_period = per; emu_single = single; cfg_noise_en = nz;
    endtask

    // Rising edge of emu_enable; the following tick is the IDLE->RUN edge.
    task automatic start_run();
        emu_enable = 1'b1;
        tick();
    endtask

    task automatic run_words(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            ca[i] = adc_data_a; cb[i] = adc_data_b; cc[i] = adc_data_c; cd[i] = adc_data_d;
            cfs[i] = frame_start; cfc[i] = frame_cnt;
            cv[i] = {adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d,
                     adc_enable_a, adc_enable_b, adc_enable_c, adc_enable_d};
        end
    endtask

    task automatic stop_run();
        emu_enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rxrstn = 1'b0; emu_enable = 1'b0;
        set_cfg(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick(); tick();
        rxrstn = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if ({adc_data_a, adc_data_b, adc_data_c, adc_data_d} !== 128'd0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h expected 0",
                               adc_data_a, adc_data_b, adc_data_c, adc_data_d);
        end
        n_tests++;
        if ({adc_valid_a, adc_valid_b, adc_valid_c, adc_valid_d, adc_enable_a, adc_enable_b,
             adc_enable_c, adc_enable_d, frame_start, busy} !== 10'd0) begin
            n_fail++; $display("FAIL reset_ctrl: valid/enable/frame_start/busy not all 0");
        end
        n_tests++;
        if (frame_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt);
        end
    endtask

    task automatic test_basic_frame();
        set_cfg(16'd0, 16'd1000, 16'd2000, 16'd3000, 16'd4, 32'd10, 32'd250, 32'd6,
                32'd1000, 1'b1, 1'b0);
        start_run();
        run_words(500);
        n_tests++;
        if (cd[0] !== 32'hFFAC_FFE1) begin
            n_fail++; $display("FAIL lfsr_idle_seed: D word0 got %h expected ffacffe1", cd[0]);
        end
        n_tests++;
        if (cfs[0] !== 1'b1 || cfs[1] !== 1'b0 || cfs[499] !== 1'b0) begin
            n_fail++; $display("FAIL basic_frame_start: w0=%b w1=%b w499=%b expected 1 0 0",
                               cfs[0], cfs[1], cfs[499]);
        end
        n_tests++;
        if (cv[0] !== 8'hFF || cv[499] !== 8'hFF) begin
            n_fail++; $display("FAIL basic_valid: w0=%h w499=%h expected ff", cv[0], cv[499]);
        end
        n_tests++;
        if (ca[4] !== 32'd0 || ca[5] !== 32'h03E8_03E8 || ca[6] !== 32'h03E8_03E8 ||
            ca[7] !== 32'd0) begin
            n_fail++; $display("FAIL basic_pulse_a: w4..7 got %h %h %h %h expected 0 03e803e8 03e803e8 0",
                               ca[4], ca[5], ca[6], ca[7]);
        end
        n_tests++;
        if (cb[129] !== 32'd0 || cb[130] !== 32'h07D0_07D0 || cb[131] !== 32'h07D0_07D0 ||
            cb[132] !== 32'd0) begin
            n_fail++; $display("FAIL basic_pulse_b: w129..132 got %h %h %h %h", cb[129], cb[130],
                               cb[131], cb[132]);
        end
        n_tests++;
        if (cc[132] !== 32'd0 || cc[133] !== 32'h0BB8_0BB8 || cc[134] !== 32'h0BB8_0BB8 ||
            cc[135] !== 32'd0) begin
            n_fail++; $display("FAIL basic_pulse_c: w132..135 got %h %h %h %h", cc[132], cc[133],
                               cc[134], cc[135]);
        end
        n_tests++;
        if (ca[130] !== 32'd0 || cb[5] !== 32'd0) begin
            n_fail++; $display("FAIL basic_independent: a130=%h b5=%h expected 0", ca[130], cb[5]);
        end
        tick();
        n_tests++;
        if (adc_valid_a !== 1'b0 || busy !== 1'b0 || frame_cnt !== 32'd1 || adc_data_a !== 32'd0) begin
            n_fail++; $display("FAIL basic_done: valid=%b busy=%b frame_cnt=%0d data=%h expected 0 0 1 0",
                               adc_valid_a, busy, frame_cnt, adc_data_a);
        end
        stop_run();
    endtask

    task automatic test_odd_align();
        set_cfg(16'd0, 16'd1000, 16'd0, 16'd0, 16'd3, 32'd11, 32'd200, 32'd0,
                32'd100, 1'b1, 1'b0);
        start_run();
        run_words(50);
        n_tests++;
        if (ca[5] !== 32'h03E8_0000 || ca[6] !== 32'h03E8_03E8 || ca[7] !== 32'd0) begin
            n_fail++; $display("FAIL odd_align: w5..7 got %h %h %h expected 03e80000 03e803e8 0",
                               ca[5], ca[6], ca[7]);
        end
        stop_run();
    endtask

    task automatic test_saturation();
        set_cfg(16'd30000, 16'd0, 16'd5000, 16'd0, 16'd2, 32'd0, 32'd4, 32'd100,
                32'd20, 1'b1, 1'b0);
        start_run();
        run_words(10);
        n_tests++;
        if (cb[2] !== 32'h7FFF_7FFF || cb[0] !== 32'h7530_7530) begin
            n_fail++; $display("FAIL sat_pos: w2=%h w0=%h expected 7fff7fff 75307530", cb[2], cb[0]);
        end
        tick();
        n_tests++;
        if (adc_data_a !== 32'h7530_7530 || adc_valid_a !== 1'b0) begin
            n_fail++; $display("FAIL done_baseline: data=%h valid=%b expected 75307530 0",
                               adc_data_a, adc_valid_a);
        end
        stop_run();
        set_cfg(16'h8AD0, 16'd0, 16'hEC78, 16'd0, 16'd2, 32'd0, 32'd4, 32'd100,
                32'd20, 1'b1, 1'b0);
        start_run();
        run_words(10);
        n_tests++;
        if (cb[2] !== 32'h8000_8000 || cb[3] !== 32'h8AD0_8AD0) begin
            n_fail++; $display("FAIL sat_neg: w2=%h w3=%h expected 80008000 8ad08ad0", cb[2], cb[3]);
        end
        stop_run();
    endtask

    task automatic test_continuous();
        set_cfg(16'd0, 16'd1000, 16'd0, 16'd0, 16'd10, 32'd98, 32'd500, 32'd0,
                32'd101, 1'b0, 1'b0);
        start_run();
        run_words(150);
        n_tests++;
        if (cfs[0] !== 1'b1 || cfs[50] !== 1'b1 || cfs[100] !== 1'b1 || cfs[49] !== 1'b0 ||
            cfs[51] !== 1'b0) begin
            n_fail++; $display("FAIL cont_frame_start: w0=%b w49=%b w50=%b w51=%b w100=%b",
                               cfs[0], cfs[49], cfs[50], cfs[51], cfs[100]);
        end
        n_tests++;
        if (cfc[49] !== 32'd1 || cfc[149] !== 32'd3) begin
            n_fail++; $display("FAIL cont_frame_cnt: w49=%0d w149=%0d expected 1 3", cfc[49], cfc[149]);
        end
        n_tests++;
        if (ca[48] !== 32'd0 || ca[49] !== 32'h03E8_03E8 || ca[50] !== 32'd0 ||
            ca[51] !== 32'd0 || ca[99] !== 32'h03E8_03E8) begin
            n_fail++; $display("FAIL cont_truncate: w48..51 %h %h %h %h w99 %h",
                               ca[48], ca[49], ca[50], ca[51], ca[99]);
        end
        emu_enable = 1'b0;
        tick();
        n_tests++;
        if (adc_valid_a !== 1'b0 || adc_data_a !== 32'd0 || frame_cnt !== 32'd3) begin
            n_fail++; $display("FAIL cont_stop: valid=%b data=%h frame_cnt=%0d expected 0 0 3",
                               adc_valid_a, adc_data_a, frame_cnt);
        end
        tick();
    endtask

    task automatic test_abort_restart();
        set_cfg(16'd0, 16'd1000, 16'd0, 16'd0, 16'd8, 32'd10, 32'd500, 32'd0,
                32'd1000, 1'b0, 1'b1);
        start_run();
        run_words(6);
        for (int i = 0; i < 6; i++) saved_d[i] = cd[i];
        n_tests++;
        if (ca[0] !== 32'hFFFE_0001 || ca[1] !== 32'hFFFC_0003) begin
            n_fail++; $display("FAIL noise_a: w0=%h w1=%h expected fffe0001 fffc0003", ca[0], ca[1]);
        end
        n_tests++;
        if (cd[0] !== 32'hFFAC_FFE1 || cd[1] !== 32'h0059_FFC3) begin
            n_fail++; $display("FAIL noise_d: w0=%h w1=%h expected ffacffe1 0059ffc3", cd[0], cd[1]);
        end
        emu_enable = 1'b0;
        tick();
        n_tests++;
        if (adc_valid_a !== 1'b0 || busy !== 1'b0 || adc_data_a !== 32'd0 || adc_data_d !== 32'd0) begin
            n_fail++; $display("FAIL abort: valid=%b busy=%b a=%h d=%h expected 0 0 0 0",
                               adc_valid_a, busy, adc_data_a, adc_data_d);
        end
        tick();
        start_run();
        run_words(6);
        n_tests++;
        if (cfs[0] !== 1'b1 || ca[0] !== 32'hFFFE_0001) begin
            n_fail++; $display("FAIL restart_t0: frame_start=%b a0=%h expected 1 fffe0001", cfs[0], ca[0]);
        end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (cd[i] !== saved_d[i]) begin
                n_fail++; $display("FAIL restart_d_w%0d: got %h expected %h", i, cd[i], saved_d[i]);
            end
        end
        stop_run();
    endtask

    task automatic test_async_reset();
        set_cfg(16'd0, 16'd1000, 16'd0, 16'd0, 16'd1, 32'd0, 32'd500, 32'd0,
                32'd4, 1'b0, 1'b0);
        start_run();
        run_words(5);
        n_tests++;
        if (cfc[4] !== 32'd2) begin
            n_fail++; $display("FAIL async_pre_cnt: got %0d expected 2", cfc[4]);
        end
        #2;
        rxrstn = 1'b0;
        #1;
        n_tests++;
        if (adc_valid_a !== 1'b0 || busy !== 1'b0 || frame_cnt !== 32'd0 || adc_data_a !== 32'd0) begin
            n_fail++; $display("FAIL async_reset: valid=%b busy=%b frame_cnt=%0d data=%h expected 0 0 0 0",
                               adc_valid_a, busy, frame_cnt, adc_data_a);
        end
        emu_enable = 1'b0;
        tick();
        rxrstn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_odd_align();
        test_saturation();
        test_continuous();
        test_abort_restart();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
